// File: rtl/store_queue_ctrl.sv
// Store-queue controller: alloc/exec/commit tracking, in-order drain, load-forward match.
// Optional stall counter output enabled by defining SQ_STALL_CNT_EN.
module store_queue_ctrl #(
  parameter int SQ_NUM   = 8,
  parameter int SQ_WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  output logic [SQ_WIDTH-1:0] alloc_index,
  input  logic                exec_valid,
  input  logic [SQ_WIDTH-1:0] exec_index,
  input  logic [31:0]         exec_addr,
  input  logic [31:0]         exec_data,
  input  logic [3:0]          exec_be,
  input  logic                commit_valid,
  output logic                commit_ready,
  input  logic                flush,
  input  logic [31:0]         ld_addr,
  output logic [SQ_NUM-1:0]   match,
  output logic [SQ_WIDTH-1:0] push_head,
  output logic                mem_req_valid,
  output logic [31:0]         mem_req_addr,
  output logic [31:0]         mem_req_data,
  output logic [3:0]          mem_req_be,
`ifdef SQ_STALL_CNT_EN
  output logic [31:0]         stall_cnt,
`endif
  input  logic                mem_req_ready
);

  typedef enum logic [1:0] {
    S_FREE,
    S_ALLOC,
    S_READY,
    S_COMMIT
  } sq_state_e;

  typedef enum logic {
    D_IDLE,
    D_REQ
  } drain_state_e;

  localparam logic [SQ_WIDTH:0] PONE = 1;

  sq_state_e    r_state [SQ_NUM];
  logic [31:0]  r_addr  [SQ_NUM];
  logic [31:0]  r_data  [SQ_NUM];
  logic [3:0]   r_be    [SQ_NUM];

  logic [SQ_WIDTH:0] r_head;
  logic [SQ_WIDTH:0] r_cptr;
  logic [SQ_WIDTH:0] r_tail;

  drain_state_e r_dstate;
  logic         r_mem_valid;
  logic [31:0]  r_mem_addr;
  logic [31:0]  r_mem_data;
  logic [3:0]   r_mem_be;

  logic [SQ_WIDTH-1:0] w_head_lo;
  logic [SQ_WIDTH-1:0] w_cptr_lo;
  logic [SQ_WIDTH-1:0] w_tail_lo;
  logic                w_full;
  logic                w_alloc;
  logic                w_exec;
  logic                w_commit;
  logic                w_drain;
  logic [SQ_WIDTH:0]   w_cptr_nxt;
  logic                w_unused;

  assign w_head_lo = r_head[SQ_WIDTH-1:0];
  assign w_cptr_lo = r_cptr[SQ_WIDTH-1:0];
  assign w_tail_lo = r_tail[SQ_WIDTH-1:0];

  assign w_full = (w_tail_lo == w_head_lo) &&
                  (r_tail[SQ_WIDTH] != r_head[SQ_WIDTH]);

  assign alloc_ready  = !w_full;
  assign alloc_index  = w_tail_lo;
  assign push_head    = w_tail_lo;
  assign commit_ready = (r_cptr != r_tail) &&
                        (r_state[w_cptr_lo] == S_READY);

  // Flush wins over alloc/exec; commit is not blocked by flush.
  assign w_alloc  = alloc_valid && !w_full && !flush;
  assign w_exec   = exec_valid && !flush &&
                    (r_state[exec_index] == S_ALLOC);
  assign w_commit = commit_valid && commit_ready;
  assign w_drain  = (r_dstate == D_REQ) && mem_req_ready;

  assign w_cptr_nxt = w_commit ? r_cptr + PONE : r_cptr;

  assign w_unused = ^ld_addr[1:0];

  always_comb begin
    match = '0;
    for (int i = 0; i < SQ_NUM; i++) begin
      match[i] = ((r_state[i] == S_READY) ||
                  (r_state[i] == S_COMMIT)) &&
                 (r_addr[i][31:2] == ld_addr[31:2]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SQ_NUM; i++) begin
        r_state[i] <= S_FREE;
        r_addr[i]  <= '0;
        r_data[i]  <= '0;
        r_be[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < SQ_NUM; i++) begin
        if (w_exec && exec_index == SQ_WIDTH'(i)) begin
          r_state[i] <= S_READY;
          r_addr[i]  <= exec_addr;
          r_data[i]  <= exec_data;
          r_be[i]    <= exec_be;
        end
        if (w_alloc && w_tail_lo == SQ_WIDTH'(i))
          r_state[i] <= S_ALLOC;
        if (flush && (r_state[i] == S_ALLOC ||
                      r_state[i] == S_READY))
          r_state[i] <= S_FREE;
        if (w_commit && w_cptr_lo == SQ_WIDTH'(i))
          r_state[i] <= S_COMMIT;
        if (w_drain && w_head_lo == SQ_WIDTH'(i))
          r_state[i] <= S_FREE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cptr <= '0;
      r_tail <= '0;
    end else begin
      r_cptr <= w_cptr_nxt;
      if (flush)
        r_tail <= w_cptr_nxt;
      else if (w_alloc)
        r_tail <= r_tail + PONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dstate    <= D_IDLE;
      r_head      <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_be    <= '0;
    end else begin
      unique case (r_dstate)
        D_IDLE: begin
          if (r_head != r_cptr) begin
            r_mem_addr  <= r_addr[w_head_lo];
            r_mem_data  <= r_data[w_head_lo];
            r_mem_be    <= r_be[w_head_lo];
            r_mem_valid <= 1'b1;
            r_dstate    <= D_REQ;
          end
        end
        D_REQ: begin
          if (mem_req_ready) begin
            r_mem_valid <= 1'b0;
            r_head      <= r_head + PONE;
            r_dstate    <= D_IDLE;
          end
        end
        default: r_dstate <= D_IDLE;
      endcase
    end
  end

  assign mem_req_valid = r_mem_valid;
  assign mem_req_addr  = r_mem_addr;
  assign mem_req_data  = r_mem_data;
  assign mem_req_be    = r_mem_be;

`ifdef SQ_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (alloc_valid && w_full && r_stall_cnt != 32'hFFFF_FFFF)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Directed self-checking bench for store_queue_ctrl.
module tb_store_queue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [2:0]  alloc_index;
  logic        exec_valid;
  logic [2:0]  exec_index;
  logic [31:0] exec_addr;
  logic [31:0] exec_data;
  logic [3:0]  exec_be;
  logic        commit_valid;
  logic        commit_ready;
  logic        flush;
  logic [31:0] ld_addr;
  logic [7:0]  match;
  logic [2:0]  push_head;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_be;
  logic        mem_req_ready;

  int errors = 0;
  int checks = 0;

  store_queue_ctrl #(.SQ_NUM(8), .SQ_WIDTH(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_index   (alloc_index),
    .exec_valid    (exec_valid),
    .exec_index    (exec_index),
    .exec_addr     (exec_addr),
    .exec_data     (exec_data),
    .exec_be       (exec_be),
    .commit_valid  (commit_valid),
    .commit_ready  (commit_ready),
    .flush         (flush),
    .ld_addr       (ld_addr),
    .match         (match),
    .push_head     (push_head),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_be    (mem_req_be),
    .mem_req_ready (mem_req_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_exec(input logic [2:0] idx,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0] be);
    exec_valid = 1'b1;
    exec_index = idx;
    exec_addr  = a;
    exec_data  = d;
    exec_be    = be;
  endtask

  initial begin
    reset = 1'b1;
    alloc_valid = 0;
    exec_valid = 0;
    exec_index = 0;
    exec_addr = 0;
    exec_data = 0;
    exec_be = 0;
    commit_valid = 0;
    flush = 0;
    ld_addr = 0;
    mem_req_ready = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_alloc_ready", 32'(alloc_ready), 1);
    check("rst_alloc_index", 32'(alloc_index), 0);
    check("rst_push_head", 32'(push_head), 0);
    check("rst_commit_ready", 32'(commit_ready), 0);
    check("rst_match", 32'(match), 0);
    check("rst_mem_valid", 32'(mem_req_valid), 0);
    check("rst_mem_addr", mem_req_addr, 0);
    check("rst_mem_data", mem_req_data, 0);
    reset = 1'b0;

    // fill all 8 entries
    alloc_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("fill_index", 32'(alloc_index), 32'(i));
      check("fill_ready", 32'(alloc_ready), 1);
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    check("full_ready", 32'(alloc_ready), 0);
    check("full_index", 32'(alloc_index), 0);
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    #1;
    check("full_push_head", 32'(push_head), 0);
    check("full_ready2", 32'(alloc_ready), 0);

    // exec and forward match
    do_exec(3'd0, 32'h40, 32'h11, 4'hF);
    tick();
    do_exec(3'd2, 32'h100, 32'hDEADBEEF, 4'hF);
    ld_addr = 32'h102;
    #1;
    check("match_pre", 32'(match), 0);
    tick();
    exec_valid = 1'b0;
    #1;
    check("match_102", 32'(match), 32'h04);
    ld_addr = 32'h104;
    #1;
    check("match_104", 32'(match), 0);
    ld_addr = 32'h40;
    #1;
    check("match_40", 32'(match), 32'h01);
    check("commit_ready0", 32'(commit_ready), 1);

    // commit and drain with backpressure
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    #1;
    check("commit_ready1", 32'(commit_ready), 0);
    check("drain_not_yet", 32'(mem_req_valid), 0);
    tick();
    check("drain_valid", 32'(mem_req_valid), 1);
    check("drain_addr", mem_req_addr, 32'h40);
    check("drain_data", mem_req_data, 32'h11);
    check("drain_be", 32'(mem_req_be), 32'hF);
    check("match_committed", 32'(match), 32'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", 32'(mem_req_valid), 1);
      check("hold_addr", mem_req_addr, 32'h40);
      check("hold_data", mem_req_data, 32'h11);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    check("drain_done", 32'(mem_req_valid), 0);
    check("freed_match", 32'(match), 0);
    check("freed_ready", 32'(alloc_ready), 1);
    check("wrap_index", 32'(alloc_index), 0);

    // 9th alloc wraps into slot 0
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    #1;
    check("wrap_full", 32'(alloc_ready), 0);
    check("wrap_push_head", 32'(push_head), 1);

    // clean restart
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst2_ready", 32'(alloc_ready), 1);
    check("rst2_push_head", 32'(push_head), 0);

    // flush with one committed entry
    alloc_valid = 1'b1;
    repeat (4) tick();
    alloc_valid = 1'b0;
    do_exec(3'd0, 32'h40, 32'h11, 4'hF);
    tick();
    exec_valid = 1'b0;
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_push_head", 32'(push_head), 1);
    check("flush_index", 32'(alloc_index), 1);
    check("flush_ready", 32'(alloc_ready), 1);
    check("flush_commit_rdy", 32'(commit_ready), 0);
    check("flush_drain_valid", 32'(mem_req_valid), 1);
    check("flush_drain_addr", mem_req_addr, 32'h40);
    do_exec(3'd1, 32'h200, 32'h22, 4'hF);
    ld_addr = 32'h200;
    tick();
    exec_valid = 1'b0;
    #1;
    check("flush_freed_exec", 32'(match), 0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    check("flush_drain_done", 32'(mem_req_valid), 0);

    // flush + alloc + commit in one cycle
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    do_exec(3'd1, 32'h300, 32'h33, 4'h3);
    tick();
    exec_valid = 1'b0;
    #1;
    check("sim_commit_rdy", 32'(commit_ready), 1);
    flush = 1'b1;
    alloc_valid = 1'b1;
    commit_valid = 1'b1;
    tick();
    flush = 1'b0;
    alloc_valid = 1'b0;
    commit_valid = 1'b0;
    #1;
    check("sim_index", 32'(alloc_index), 2);
    check("sim_push_head", 32'(push_head), 2);
    check("sim_commit_rdy2", 32'(commit_ready), 0);
    tick();
    ld_addr = 32'h300;
    #1;
    check("sim_drain_valid", 32'(mem_req_valid), 1);
    check("sim_drain_addr", mem_req_addr, 32'h300);
    check("sim_drain_data", mem_req_data, 32'h33);
    check("sim_drain_be", 32'(mem_req_be), 32'h3);
    check("sim_match", 32'(match), 32'h02);

    // reset during an outstanding request
    reset = 1'b1;
    #1;
    check("rmid_valid", 32'(mem_req_valid), 0);
    check("rmid_addr", mem_req_addr, 0);
    check("rmid_index", 32'(alloc_index), 0);
    check("rmid_push_head", 32'(push_head), 0);
    check("rmid_commit_rdy", 32'(commit_ready), 0);
    check("rmid_match", 32'(match), 0);
    tick();
    reset = 1'b0;
    tick();
    check("rmid_after", 32'(mem_req_valid), 0);
    check("rmid_ready", 32'(alloc_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
